// File: rtl/tri_pixel_collector.sv
// rtl/tri_pixel_collector.sv - captures a rasterizer point stream into an 8x8 bitmap and reads it out row by row
//
// Purpose:
//   Collects the points of one triangle (busy high) into an 8x8 bitmap, counts
//   distinct pixels, flags duplicates and lost streams, then on request streams
//   the bitmap out as 8 registered rows.
//
// Optional feature:
//   TRI_ORDER_CHECK_EN - when defined, flags points not in strictly increasing
//   {y,x} raster order via ord_err. When undefined, ord_err is tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   busy      in   rasterizer busy (point stream active)
//   po        in   point-valid strobe
//   xo, yo    in   point coordinates 0..7
//   rd_req    in   readout request
//   done      out  frame captured, readout available
//   row_vld   out  row_idx/row_data valid
//   row_idx   out  row number being output
//   row_data  out  row bitmap, bit x = pixel (x,row_idx)
//   pix_cnt   out  distinct pixel count, 0..64
//   dup_err   out  sticky duplicate-pixel flag
//   lost_err  out  sticky flag: stream started while not idle
//   ord_err   out  sticky raster-order violation flag

module tri_pixel_collector (
  input  logic       clk,
  input  logic       reset,
  input  logic       busy,
  input  logic       po,
  input  logic [2:0] xo,
  input  logic [2:0] yo,
  input  logic       rd_req,
  output logic       done,
  output logic       row_vld,
  output logic [2:0] row_idx,
  output logic [7:0] row_data,
  output logic [6:0] pix_cnt,
  output logic       dup_err,
  output logic       lost_err,
  output logic       ord_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE, READOUT} state_t;

  state_t     state;
  logic [7:0] bitmap [8];

  logic       hit;
  logic [6:0] cnt_inc;

  assign hit     = bitmap[yo][xo];
  // 64 is the ceiling; duplicates never count, so this only guards the arithmetic.
  assign cnt_inc = (pix_cnt == 7'd64) ? pix_cnt : pix_cnt + 7'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      row_vld  <= 1'b0;
      row_idx  <= 3'd0;
      row_data <= 8'd0;
      pix_cnt  <= 7'd0;
      dup_err  <= 1'b0;
      lost_err <= 1'b0;
      for (int r = 0; r < 8; r++) bitmap[r] <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // po in IDLE only matters on the cycle busy rises.
          if (busy) begin
            state    <= COLLECT;
            dup_err  <= 1'b0;
            lost_err <= 1'b0;
            // Bitmap is always clear in IDLE, so a first point is never a duplicate.
            pix_cnt  <= po ? 7'd1 : 7'd0;
            if (po) bitmap[yo][xo] <= 1'b1;
          end
        end
        COLLECT: begin
          if (po) begin
            bitmap[yo][xo] <= 1'b1;
            if (hit) dup_err <= 1'b1;
            else     pix_cnt <= cnt_inc;
          end
          if (!busy) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (busy) lost_err <= 1'b1;
          if (rd_req) begin
            state    <= READOUT;
            done     <= 1'b0;
            row_vld  <= 1'b1;
            row_idx  <= 3'd0;
            row_data <= bitmap[0];
          end
        end
        READOUT: begin
          if (busy) lost_err <= 1'b1;
          if (row_idx == 3'd7) begin
            state    <= IDLE;
            row_vld  <= 1'b0;
            row_idx  <= 3'd0;
            row_data <= 8'd0;
            for (int r = 0; r < 8; r++) bitmap[r] <= 8'd0;
          end else begin
            row_idx  <= row_idx + 3'd1;
            row_data <= bitmap[row_idx + 3'd1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRI_ORDER_CHECK_EN
  logic [5:0] prev_key;
  logic       prev_vld;
  logic       out_of_order;

  assign out_of_order = prev_vld && ({yo, xo} <= prev_key);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_key <= 6'd0;
      prev_vld <= 1'b0;
      ord_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (busy) begin
            // A point on the entry cycle is the first of the frame: nothing to compare.
            ord_err  <= 1'b0;
            prev_vld <= po;
            prev_key <= {yo, xo};
          end
        end
        COLLECT: begin
          if (po) begin
            if (out_of_order) ord_err <= 1'b1;
            prev_vld <= 1'b1;
            prev_key <= {yo, xo};
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign ord_err = 1'b0;
`endif

endmodule

// File: tb/tb_tri_pixel_collector.sv
// tb/tb_tri_pixel_collector.sv - self-checking bench for tri_pixel_collector

module tb_tri_pixel_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy = 1'b0;
  logic       po = 1'b0;
  logic [2:0] xo = 3'd0;
  logic [2:0] yo = 3'd0;
  logic       rd_req = 1'b0;
  logic       done;
  logic       row_vld;
  logic [2:0] row_idx;
  logic [7:0] row_data;
  logic [6:0] pix_cnt;
  logic       dup_err;
  logic       lost_err;
  logic       ord_err;

  tri_pixel_collector dut (
    .clk(clk), .reset(reset), .busy(busy), .po(po), .xo(xo), .yo(yo),
    .rd_req(rd_req), .done(done), .row_vld(row_vld), .row_idx(row_idx),
    .row_data(row_data), .pix_cnt(pix_cnt), .dup_err(dup_err),
    .lost_err(lost_err), .ord_err(ord_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Frame-level reference model
  localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_DONE = 2, PH_READ = 3;
  int m_phase;
  bit m_bm [8][8];
  int m_cnt;
  bit m_dup, m_lost, m_ord;
  int m_prev;
  bit m_prev_vld;
  int rowq [$];
  int e_done, e_vld, e_idx, e_data;

  int got_rows [8];
  int lit_rows [8];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int row_value(int r);
    int v = 0;
    for (int x = 0; x < 8; x++) if (m_bm[r][x]) v += (1 << x);
    return v;
  endfunction

  function automatic void model_reset();
    m_phase = PH_IDLE;
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) m_bm[y][x] = 1'b0;
    m_cnt = 0; m_dup = 0; m_lost = 0; m_ord = 0;
    m_prev = 0; m_prev_vld = 0;
    rowq.delete();
    e_done = 0; e_vld = 0; e_idx = 0; e_data = 0;
  endfunction

  function automatic void model_capture(int x, int y);
    int key = y * 8 + x;
`ifdef TRI_ORDER_CHECK_EN
    if (m_prev_vld && key <= m_prev) m_ord = 1;
`endif
    m_prev = key;
    m_prev_vld = 1;
    if (m_bm[y][x]) m_dup = 1;
    else begin
      m_bm[y][x] = 1;
      if (m_cnt < 64) m_cnt++;
    end
  endfunction

  function automatic void model_step(int b, int p, int x, int y, int r);
    case (m_phase)
      PH_IDLE: if (b != 0) begin
        m_phase = PH_COLLECT;
        m_cnt = 0; m_dup = 0; m_lost = 0; m_ord = 0; m_prev_vld = 0;
        if (p != 0) model_capture(x, y);
      end
      PH_COLLECT: begin
        if (p != 0) model_capture(x, y);
        if (b == 0) begin m_phase = PH_DONE; e_done = 1; end
      end
      PH_DONE: begin
        if (b != 0) m_lost = 1;
        if (r != 0) begin
          m_phase = PH_READ;
          e_done = 0;
          rowq.delete();
          for (int i = 0; i < 8; i++) rowq.push_back(row_value(i));
          e_vld = 1; e_idx = 0; e_data = rowq.pop_front();
        end
      end
      default: begin
        if (b != 0) m_lost = 1;
        if (rowq.size() == 0) begin
          m_phase = PH_IDLE;
          e_vld = 0; e_idx = 0; e_data = 0;
          for (int yy = 0; yy < 8; yy++) for (int xx = 0; xx < 8; xx++) m_bm[yy][xx] = 1'b0;
        end else begin
          e_idx = e_idx + 1;
          e_data = rowq.pop_front();
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", int'(done), e_done);
      chk("row_vld", int'(row_vld), e_vld);
      chk("row_idx", int'(row_idx), e_idx);
      chk("row_data", int'(row_data), e_data);
      chk("pix_cnt", int'(pix_cnt), m_cnt);
      chk("dup_err", int'(dup_err), int'(m_dup));
      chk("lost_err", int'(lost_err), int'(m_lost));
      chk("ord_err", int'(ord_err), int'(m_ord));
      if (row_vld) got_rows[row_idx] = int'(row_data);
    end
  end

  task automatic cyc(int b, int p, int x, int y, int r);
    busy = (b != 0); po = (p != 0); xo = 3'(x); yo = 3'(y); rd_req = (r != 0);
    @(posedge clk);
    #1;
    model_step(b, p, x, y, r);
  endtask

  task automatic read_frame();
    for (int i = 0; i < 8; i++) got_rows[i] = -1;
    cyc(0, 0, 0, 0, 1);
    repeat (8) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    busy = 0; po = 0; rd_req = 0;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_row_vld", int'(row_vld), 0);
    chk("rst_row_idx", int'(row_idx), 0);
    chk("rst_row_data", int'(row_data), 0);
    chk("rst_pix_cnt", int'(pix_cnt), 0);
    chk("rst_errs", int'({dup_err, lost_err, ord_err}), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int exp_ord;
    model_reset();
    #12;
    chk("reset_state", int'({done, row_vld, row_idx, row_data, pix_cnt, dup_err, lost_err, ord_err}), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // V1: four points then readout
    cyc(1, 1, 1, 0, 0); cyc(1, 1, 1, 1, 0); cyc(1, 1, 2, 1, 0); cyc(1, 1, 1, 2, 0);
    cyc(0, 0, 0, 0, 0);
    chk("v1_done", int'(done), 1);
    chk("v1_cnt", int'(pix_cnt), 4);
    read_frame();
    lit_rows = '{8'h02, 8'h06, 8'h02, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) chk($sformatf("v1_row%0d", i), got_rows[i], lit_rows[i]);
    chk("v1_idle_done", int'(done), 0);

    // V2: duplicate point; a stray po in IDLE without busy is ignored first
    cyc(0, 1, 4, 4, 0);
    cyc(1, 1, 3, 3, 0); cyc(1, 1, 3, 3, 0); cyc(0, 0, 0, 0, 0);
    chk("v2_dup", int'(dup_err), 1);
    chk("v2_cnt", int'(pix_cnt), 1);
    read_frame();
    chk("v2_row3", got_rows[3], 8'h08);
    chk("v2_row4", got_rows[4], 0);

    // V3: points on entry and exit cycles
    cyc(1, 1, 0, 0, 0); cyc(0, 1, 7, 7, 0);
    chk("v3_cnt", int'(pix_cnt), 2);
    read_frame();
    chk("v3_row0", got_rows[0], 8'h01);
    chk("v3_row7", got_rows[7], 8'h80);
    chk("v3_dup_hold", int'(dup_err), 0);

    // V4: stream while in DONE
    cyc(1, 1, 4, 2, 0); cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 0); cyc(1, 1, 6, 6, 0); cyc(0, 0, 0, 0, 0);
    chk("v4_lost", int'(lost_err), 1);
    chk("v4_cnt", int'(pix_cnt), 1);
    read_frame();
    chk("v4_row2", got_rows[2], 8'h10);
    chk("v4_row5", got_rows[5], 0);
    chk("v4_row6", got_rows[6], 0);
    chk("v4_lost_hold", int'(lost_err), 1);

    // V5: reset during readout row 3
    cyc(1, 1, 2, 3, 0); cyc(1, 1, 5, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    chk("v5_row_idx", int'(row_idx), 3);
    chk("v5_row_data", int'(row_data), 8'h04);
    chk("v5_cnt_pre", int'(pix_cnt), 2);
    rst_pulse();
    cyc(1, 1, 1, 1, 0); cyc(0, 0, 0, 0, 0);
    read_frame();
    lit_rows = '{0, 8'h02, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) chk($sformatf("v5_row%0d", i), got_rows[i], lit_rows[i]);

    // V6: raster-order violation
    cyc(1, 1, 2, 2, 0); cyc(1, 1, 1, 2, 0); cyc(0, 0, 0, 0, 0);
`ifdef TRI_ORDER_CHECK_EN
    exp_ord = 1;
`else
    exp_ord = 0;
`endif
    chk("v6_ord", int'(ord_err), exp_ord);
    read_frame();

    // Full bitmap plus a duplicate: count stops at 64
    for (int k = 0; k < 64; k++) cyc(1, 1, k % 8, k / 8, 0);
    cyc(1, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    chk("sat_cnt", int'(pix_cnt), 64);
    chk("sat_dup", int'(dup_err), 1);
    read_frame();
    for (int i = 0; i < 8; i++) chk($sformatf("sat_row%0d", i), got_rows[i], 8'hFF);

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      repeat ($urandom_range(0, 2))
        cyc(0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      repeat ($urandom_range(1, 20))
        cyc(1, $urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      cyc(0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), 0);
      repeat ($urandom_range(0, 3))
        cyc($urandom_range(0, 4) == 0, 1, $urandom_range(0, 7), $urandom_range(0, 7), 0);
      cyc(0, 0, 0, 0, 1);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 6)) cyc(0, 0, 0, 0, 0);
        rst_pulse();
      end else begin
        repeat (8)
          cyc($urandom_range(0, 5) == 0, 1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1));
      end
    end
    repeat (12) cyc(0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tri_pixel_collector.md
TRI_PIXEL_COLLECTOR -- requirements
Module: tri_pixel_collector

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
  clk       in   1  single clock; all state updates on rising edge.
  reset     in   1  asynchronous, active-low reset.
  busy      in   1  rasterizer busy; high while a triangle's point stream is active.
  po        in   1  point-valid strobe from rasterizer.
  xo        in   3  point x coordinate, 0..7.
  yo        in   3  point y coordinate, 0..7.
  rd_req    in   1  request to read out the captured bitmap.
  done      out  1  frame captured; readout available.
  row_vld   out  1  row_data/row_idx valid this cycle.
  row_idx   out  3  row number (y) being output.
  row_data  out  8  row bitmap; bit x = pixel (x,row_idx).
  pix_cnt   out  7  count of distinct pixels captured, 0..64.
  dup_err   out  1  sticky; a pixel was reported twice in the frame.
  lost_err  out  1  sticky; a new stream started while not in IDLE.
  ord_err   out  1  sticky; raster-order violation (see Configuration).

Function
REQ-002 State machine SHALL have states IDLE, COLLECT, DONE, READOUT.
REQ-003 IDLE: on busy=1, go to COLLECT; clear pix_cnt, dup_err, lost_err, ord_err; also capture po/xo/yo sampled that same cycle.
REQ-004 COLLECT: each cycle po=1, set bitmap[yo][xo]; if bit was 0, increment pix_cnt; if bit was 1, set dup_err and leave pix_cnt unchanged.
REQ-005 COLLECT: on busy=0, go to DONE; a po=1 sampled in that same cycle SHALL still be captured.
REQ-006 DONE: done=1; on rd_req=1, go to READOUT; busy rising while in DONE SHALL set lost_err and its points SHALL be ignored.
REQ-007 READOUT: output rows 0..7 on 8 consecutive cycles with row_vld=1, row_idx=n, row_data=bitmap[n]; first row in the cycle after rd_req is sampled.
REQ-008 After row 7, go to IDLE next cycle and clear the bitmap to all zero; done=0 from READOUT entry onward.
REQ-009 READOUT: rd_req SHALL be ignored; busy=1 SHALL set lost_err and be ignored.
REQ-010 row_vld, row_idx, row_data SHALL be registered; outside READOUT row_vld=0, row_idx=0, row_data=0.
REQ-011 pix_cnt SHALL saturate at 64; it cannot exceed 64 because duplicates are not counted.
REQ-012 pix_cnt and error flags SHALL hold their values through DONE, READOUT and IDLE until the next COLLECT entry.
REQ-013 po=1 while in IDLE with busy=0 SHALL be ignored.

Reset
REQ-014 reset=0 SHALL immediately force IDLE, bitmap all zero, and all outputs to 0 (done, row_vld, row_idx, row_data, pix_cnt, dup_err, lost_err, ord_err).
REQ-015 Reset asserted mid-COLLECT or mid-READOUT SHALL abort the frame; after release the block SHALL wait in IDLE for busy.

Configuration
REQ-016 Macro TRI_ORDER_CHECK_EN, when defined, SHALL enable raster-order checking in COLLECT: each po=1 point SHALL have {yo,xo} strictly greater than the previous point's {y,x} in the frame, else ord_err is set (point still captured).
REQ-017 Without TRI_ORDER_CHECK_EN, the order-check logic SHALL be absent and ord_err SHALL be tied to 0.

Verification
REQ-018 Bench SHALL cover:
  V1: busy 1 for 4 cycles, points (1,0),(1,1),(2,1),(1,2), busy 0; rd_req -> done=1, pix_cnt=4; rows 0..7 = 02,06,02,00,00,00,00,00 hex on 8 cycles.
  V2: point (3,3) reported twice -> dup_err=1, pix_cnt=1, row 3 = 08.
  V3: busy and po=1 at (0,0) in same IDLE cycle, then busy 0 with po=1 at (7,7) -> both captured, pix_cnt=2, row0=01, row7=80.
  V4: busy rises in DONE with points -> lost_err=1, bitmap unchanged at readout.
  V5: reset=0 during readout row 3 -> row_vld=0, done=0, pix_cnt=0 immediately; next frame reads clean bitmap.
  V6 (TRI_ORDER_CHECK_EN): points (2,2) then (1,2) -> ord_err=1; without macro ord_err=0.
